// File: rtl/ci_test_monitor.sv
// End-of-test monitor: watches per-channel ecall commits, checks result against PASS_VAL,
// runs an absolute/idle watchdog, and latches a PASS/FAIL/TIMEOUT verdict (1-cycle, registered).
module ci_test_monitor #(
  parameter int NCH = 2,
  parameter int DW  = 64,
  parameter logic [DW-1:0] PASS_VAL = DW'(1),
  parameter int TW  = 32,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              wd_mode,
  input  logic [TW-1:0]     wd_limit,
  input  logic [NCH-1:0]    commit_vld,
  input  logic [NCH-1:0]    ecall_vld,
  input  logic [NCH*DW-1:0] result,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [NCH-1:0]    ch_done,
  output logic [CW-1:0]     fail_ch,
  output logic [DW-1:0]     fail_val,
  output logic [TW-1:0]     cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic          mode_q;
  logic [TW-1:0] limit_q;
  logic [TW-1:0] idle_cnt;

  logic [NCH-1:0] new_ecall;
  logic [NCH-1:0] fail_vec;
  logic           any_fail;
  logic           all_done;
  logic           activity;
  logic           timeout;
  logic [CW-1:0]  fail_idx;
  logic [DW-1:0]  fail_res;
  logic [TW-1:0]  wd_cnt;

  always_comb begin
    new_ecall = ecall_vld & ~ch_done;
    fail_vec  = '0;
    fail_idx  = '0;
    fail_res  = '0;
    for (int i = 0; i < NCH; i++)
      fail_vec[i] = new_ecall[i] && (result[i*DW +: DW] != PASS_VAL);
    // Walk downward so the lowest failing index is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_vec[i]) begin
        fail_idx = CW'(i);
        fail_res = result[i*DW +: DW];
      end
    end
    any_fail = |fail_vec;
    all_done = &(ch_done | new_ecall);
    activity = |commit_vld || |ecall_vld;
    wd_cnt   = mode_q ? idle_cnt : cycle_cnt;
    // In idle mode an edge with progress is not an idle edge, so it cannot expire.
    timeout  = (limit_q != '0) && (wd_cnt == limit_q - TW'(1)) && !(mode_q && activity);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= 2'b00;
      ch_done   <= '0;
      fail_ch   <= '0;
      fail_val  <= '0;
      cycle_cnt <= '0;
      idle_cnt  <= '0;
      mode_q    <= 1'b0;
      limit_q   <= '0;
    end else if (start) begin
      state     <= S_RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      status    <= 2'b00;
      ch_done   <= '0;
      fail_ch   <= '0;
      fail_val  <= '0;
      cycle_cnt <= '0;
      idle_cnt  <= '0;
      mode_q    <= wd_mode;
      limit_q   <= wd_limit;
    end else if (state == S_RUN) begin
      ch_done <= ch_done | new_ecall;
      if (any_fail || all_done || timeout) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        if (any_fail) begin
          status   <= 2'b10;
          fail_ch  <= fail_idx;
          fail_val <= fail_res;
        end else if (all_done) begin
          status <= 2'b01;
        end else begin
          status <= 2'b11;
        end
      end else begin
        if (!(&cycle_cnt)) cycle_cnt <= cycle_cnt + TW'(1);
        if (activity)           idle_cnt <= '0;
        else if (!(&idle_cnt))  idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ci_test_monitor.sv
// Directed bench for ci_test_monitor (NCH=2, DW=64, TW=32): one task per scenario.
module tb_ci_test_monitor;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          wd_mode;
  logic [31:0]   wd_limit;
  logic [1:0]    commit_vld;
  logic [1:0]    ecall_vld;
  logic [127:0]  result;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [1:0]    ch_done;
  logic [0:0]    fail_ch;
  logic [63:0]   fail_val;
  logic [31:0]   cycle_cnt;

  int total = 0;
  int bad   = 0;

  ci_test_monitor #(.NCH(2), .DW(64), .PASS_VAL(64'd1), .TW(32), .CW(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .wd_mode(wd_mode), .wd_limit(wd_limit),
    .commit_vld(commit_vld), .ecall_vld(ecall_vld), .result(result),
    .busy(busy), .done(done), .status(status), .ch_done(ch_done),
    .fail_ch(fail_ch), .fail_val(fail_val), .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle 1 time unit before checks/new drives.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; commit_vld = 0; ecall_vld = 0; result = '0;
  endtask

  task automatic do_start(input logic mode, input logic [31:0] limit);
    wd_mode = mode; wd_limit = limit; start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    RST = 1; idle_inputs(); wd_mode = 0; wd_limit = 0;
    step(); step();
    RST = 0;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
    total++; if (status !== 2'b00)   begin bad++; $display("FAIL reset_status got=%0h want=0", status); end
    total++; if (ch_done !== 2'b00)  begin bad++; $display("FAIL reset_ch_done got=%0h want=0", ch_done); end
    total++; if (fail_ch !== 1'b0)   begin bad++; $display("FAIL reset_fail_ch got=%0h want=0", fail_ch); end
    total++; if (fail_val !== 64'd0) begin bad++; $display("FAIL reset_fail_val got=%0h want=0", fail_val); end
    total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_cycle_cnt got=%0h want=0", cycle_cnt); end
  endtask

  task automatic test_pass();
    idle_inputs();
    do_start(1'b0, 32'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy_after_start got=%0h want=1", busy); end
    for (int c = 1; c <= 20; c++) begin
      commit_vld = (c <= 10) ? 2'b11 : 2'b00;
      ecall_vld  = 2'b00;
      result     = '0;
      if (c == 12) begin ecall_vld = 2'b01; result = {64'd0, 64'd1}; end
      if (c == 20) begin ecall_vld = 2'b10; result = {64'd1, 64'd0}; end
      step();
      if (c == 12) begin
        total++; if (ch_done !== 2'b01)    begin bad++; $display("FAIL pass_ch_done_c12 got=%0h want=1", ch_done); end
        total++; if (busy !== 1'b1)        begin bad++; $display("FAIL pass_busy_c12 got=%0h want=1", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL pass_done_c12 got=%0h want=0", done); end
        total++; if (cycle_cnt !== 32'd12) begin bad++; $display("FAIL pass_cycle_cnt_c12 got=%0d want=12", cycle_cnt); end
      end
    end
    idle_inputs();
    total++; if (done !== 1'b1)     begin bad++; $display("FAIL pass_done got=%0h want=1", done); end
    total++; if (status !== 2'b01)  begin bad++; $display("FAIL pass_status got=%0h want=1", status); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL pass_busy_end got=%0h want=0", busy); end
    total++; if (ch_done !== 2'b11) begin bad++; $display("FAIL pass_ch_done_end got=%0h want=3", ch_done); end
  endtask

  task automatic test_simul_fail();
    idle_inputs();
    do_start(1'b0, 32'd0);
    ecall_vld = 2'b11; result = {64'h5, 64'h1};
    step();
    idle_inputs();
    total++; if (status !== 2'b10)    begin bad++; $display("FAIL sfail_status got=%0h want=2", status); end
    total++; if (fail_ch !== 1'b1)    begin bad++; $display("FAIL sfail_fail_ch got=%0h want=1", fail_ch); end
    total++; if (fail_val !== 64'h5)  begin bad++; $display("FAIL sfail_fail_val got=%0h want=5", fail_val); end
    total++; if (ch_done !== 2'b11)   begin bad++; $display("FAIL sfail_ch_done got=%0h want=3", ch_done); end
    // Re-arm directly from DONE clears the verdict.
    do_start(1'b0, 32'd0);
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL rearm_busy got=%0h want=1", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL rearm_done got=%0h want=0", done); end
    total++; if (status !== 2'b00)    begin bad++; $display("FAIL rearm_status got=%0h want=0", status); end
    total++; if (fail_val !== 64'd0)  begin bad++; $display("FAIL rearm_fail_val got=%0h want=0", fail_val); end
    total++; if (ch_done !== 2'b00)   begin bad++; $display("FAIL rearm_ch_done got=%0h want=0", ch_done); end
    ecall_vld = 2'b11; result = {64'h9, 64'h7};
    step();
    idle_inputs();
    total++; if (status !== 2'b10)    begin bad++; $display("FAIL bfail_status got=%0h want=2", status); end
    total++; if (fail_ch !== 1'b0)    begin bad++; $display("FAIL bfail_fail_ch got=%0h want=0", fail_ch); end
    total++; if (fail_val !== 64'h7)  begin bad++; $display("FAIL bfail_fail_val got=%0h want=7", fail_val); end
  endtask

  task automatic test_abs_timeout();
    idle_inputs();
    do_start(1'b0, 32'd100);
    commit_vld = 2'b11;
    for (int c = 1; c <= 99; c++) step();
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL abs_early_done got=%0h want=0", done); end
    step();
    total++; if (done !== 1'b1)       begin bad++; $display("FAIL abs_done got=%0h want=1", done); end
    total++; if (status !== 2'b11)    begin bad++; $display("FAIL abs_status got=%0h want=3", status); end
    total++; if (cycle_cnt !== 32'd99) begin bad++; $display("FAIL abs_cycle_cnt got=%0d want=99", cycle_cnt); end
    for (int c = 0; c < 5; c++) step();
    total++; if (cycle_cnt !== 32'd99) begin bad++; $display("FAIL abs_frozen got=%0d want=99", cycle_cnt); end
    // Zero limit disables the watchdog.
    idle_inputs();
    do_start(1'b0, 32'd0);
    for (int c = 0; c < 1000; c++) step();
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL wd_off_done got=%0h want=0", done); end
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL wd_off_busy got=%0h want=1", busy); end
    total++; if (cycle_cnt !== 32'd1000) begin bad++; $display("FAIL wd_off_cycle_cnt got=%0d want=1000", cycle_cnt); end
  endtask

  task automatic test_idle_timeout();
    idle_inputs();
    do_start(1'b1, 32'd8);
    for (int c = 1; c <= 35; c++) begin
      commit_vld = (c % 7 == 0) ? 2'b01 : 2'b00;
      step();
    end
    commit_vld = 2'b00;
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL idle_periodic_done got=%0h want=0", done); end
    for (int c = 1; c <= 7; c++) step();
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL idle_7th_done got=%0h want=0", done); end
    step();
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL idle_8th_done got=%0h want=1", done); end
    total++; if (status !== 2'b11) begin bad++; $display("FAIL idle_status got=%0h want=3", status); end
  endtask

  task automatic test_priority();
    idle_inputs();
    do_start(1'b0, 32'd5);
    ecall_vld = 2'b01; result = {64'd0, 64'd1};
    step();
    // Duplicate ecall with a bad result on a channel already done.
    ecall_vld = 2'b01; result = {64'd0, 64'hBAD};
    step();
    idle_inputs();
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL dup_done got=%0h want=0", done); end
    total++; if (fail_val !== 64'd0) begin bad++; $display("FAIL dup_fail_val got=%0h want=0", fail_val); end
    step(); step();
    ecall_vld = 2'b10; result = {64'd1, 64'd0};
    step();
    idle_inputs();
    total++; if (status !== 2'b01)   begin bad++; $display("FAIL prio_status got=%0h want=1", status); end
    total++; if (done !== 1'b1)      begin bad++; $display("FAIL prio_done got=%0h want=1", done); end
  endtask

  task automatic test_restart_and_reset();
    idle_inputs();
    do_start(1'b0, 32'd0);
    commit_vld = 2'b11;
    step(); step(); step();
    ecall_vld = 2'b01; result = {64'd0, 64'd1};
    step();
    idle_inputs();
    do_start(1'b0, 32'd0);
    total++; if (ch_done !== 2'b00)   begin bad++; $display("FAIL restart_ch_done got=%0h want=0", ch_done); end
    total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL restart_cycle_cnt got=%0d want=0", cycle_cnt); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL restart_busy got=%0h want=1", busy); end
    ecall_vld = 2'b01; result = {64'd0, 64'd1};
    step(); step();
    idle_inputs();
    RST = 1;
    step();
    RST = 0;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
    total++; if (ch_done !== 2'b00)   begin bad++; $display("FAIL rst_ch_done got=%0h want=0", ch_done); end
    total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL rst_cycle_cnt got=%0d want=0", cycle_cnt); end
    total++; if (status !== 2'b00)    begin bad++; $display("FAIL rst_status got=%0h want=0", status); end
    step();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_stays_idle got=%0h want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_simul_fail();
    test_abs_timeout();
    test_idle_timeout();
    test_priority();
    test_restart_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ci_test_monitor.md
# ci_test_monitor

Synthesizable end-of-test monitor for regression runs of the riftChip core. It watches NCH independent commit channels (harts or retire ports) for the terminating `ecall` and checks the per-channel result register (x3 by convention) against a pass value. It also runs a watchdog in either absolute-cycle or idle-progress mode. The result is a latched PASS/FAIL/TIMEOUT verdict, which simulation benches and FPGA CI builds read in place of hard-coded time-outs.

## Interface
- NCH, 2: number of monitored channels (1..16).
- DW, 64: width of each result value.
- PASS_VAL, 1: result value that counts as pass.
- TW, 32: width of watchdog limit and counters.
- CW, clog2(NCH) (min 1): width of channel index.
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  single-cycle arm pulse; clears all verdict state.
- wd_mode  in  1  0 = absolute (cycles since start), 1 = idle (cycles since last progress); sampled on start.
- wd_limit  in  TW  watchdog limit; sampled on start; 0 disables the watchdog.
- commit_vld  in  NCH  per-channel instruction retire strobe (progress).
- ecall_vld  in  NCH  per-channel ecall commit strobe.
- result  in  NCH*DW  per-channel result value; channel i at [i*DW +: DW]; valid when ecall_vld[i].
- busy  out  1  monitor in RUN.
- done  out  1  verdict latched.
- status  out  2  00 none, 01 pass, 10 fail, 11 timeout.
- ch_done  out  NCH  channel has reported ecall.
- fail_ch  out  CW  index of first failing channel.
- fail_val  out  DW  result value of first failing channel.
- cycle_cnt  out  TW  cycles spent in RUN, saturating at all-ones.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: on start → RUN. Sample wd_mode and wd_limit. Clear ch_done, cycle_cnt, idle counter, fail_ch, fail_val, and status.
- RUN, each cycle:
  - cycle_cnt increments, saturating.
  - Idle counter clears on any commit_vld or ecall_vld bit; otherwise it increments, saturating.
- Ecall handling in RUN, for each channel i with ecall_vld[i] and !ch_done[i]:
  - Set ch_done[i].
  - If result_i != PASS_VAL, the channel fails.
  - Ecalls on already-done channels are ignored. Their result is not re-checked.
- Fail resolution:
  - If any channel fails this cycle, latch the lowest failing index into fail_ch and its value into fail_val.
  - status = 10; go to DONE.
- Pass resolution: when every ch_done bit is set (including bits set this cycle) and no failure occurred, status = 01; go to DONE.
- Watchdog:
  - The watchdog counter is cycle_cnt in mode 0 and the idle counter in mode 1.
  - When wd_limit != 0 and the counter value before increment equals wd_limit − 1, status = 11; go to DONE.
- Priority in the same cycle: fail > pass > timeout.
- DONE: all outputs hold and counters freeze. start re-arms (behaves as in IDLE). All other inputs are ignored.
- start while in RUN: restart, with the same clearing as from IDLE. The in-progress test is discarded and no verdict is produced.
- RST at any time, including mid-RUN, forces IDLE and all outputs to 0.

## Timing
- Reset values: busy 0, done 0, status 00, ch_done 0, fail_ch 0, fail_val 0, cycle_cnt 0.
- All outputs are registered.
- start sampled at edge k → busy = 1 after edge k. The first cycle_cnt increment happens at edge k+1.
- An ecall sampled at edge n that decides the verdict → done = 1, busy = 0, and status valid after edge n. Latency is 1 cycle from strobe to verdict.
- Absolute timeout with wd_limit = L, start at edge k, no ecalls → done, status = 11 after edge k+L; cycle_cnt = L − 1 at that point, then frozen.
- Idle timeout: L consecutive edges in RUN with no commit_vld or ecall_vld → timeout.
- Combinational paths: none from inputs to outputs.

## Test plan
- Pass, NCH = 2:
  - Stimulus: start; 10 cycles of commits; ecall ch0 with result 1 at cycle 12; ecall ch1 with result 1 at cycle 20.
  - Required response: ch_done = 01 after cycle 12, busy still 1; done with status 01 after cycle 20.
- Simultaneous fail:
  - Stimulus: ecall on both channels in one cycle, ch0 result 1, ch1 result 0x5.
  - Required response: status 10, fail_ch = 1, fail_val = 0x5. Repeat with both results failing → fail_ch = 0.
- Absolute timeout:
  - Stimulus: wd_mode 0, wd_limit 100, commits every cycle, no ecall.
  - Required response: status 11 exactly 100 edges after start.
  - Stimulus: wd_limit 0 for 1000 cycles.
  - Required response: no verdict.
- Idle timeout:
  - Stimulus: wd_mode 1, wd_limit 8, commit every 7 cycles.
  - Required response: no timeout.
  - Stimulus: stop commits.
  - Required response: status 11 on the 8th idle edge.
- Priority and duplicates:
  - Stimulus: passing last ecall in the same cycle the watchdog expires.
  - Required response: status 01.
  - Stimulus: second ecall on a done channel with a bad result.
  - Required response: ignored.
- Reset and re-arm:
  - Stimulus: RST mid-RUN.
  - Required response: all outputs 0 next cycle.
  - Stimulus: start from DONE.
  - Required response: verdict cleared, busy = 1.
